// File: rtl/alu_op_decoder.sv
// -----------------------------------------------------------------------------
// alu_op_decoder
//   Producer end of the 4-bit ALU opcode interface. It accepts RV32I
//   instruction words over a valid/ready handshake and decodes opcode,
//   funct3 and funct7/imm[11:5] into an ALU operation plus an operand-B
//   select. Results leave through a registered output stage backed by a
//   one-entry skid buffer, so in_ready never depends combinationally on
//   out_ready.
//
//   Decode latency is one cycle. Throughput is one instruction per cycle.
//
// Parameters
//   TAG_W        width of the opaque tag carried with each instruction
//
// Ports
//   clk          clock, rising edge
//   rst          synchronous active-high reset
//   in_valid     instruction word valid
//   in_ready     decoder can accept (registered, = !skid_full)
//   in_instr     RV32I instruction word
//   in_tag       passthrough tag
//   out_valid    decoded result valid
//   out_ready    consumer accepts
//   out_alu_op   ALU opcode (ADD..SRA, 0..8)
//   out_src_imm  1 = operand B is the immediate, 0 = rs2
//   out_illegal  instruction not executable by the ALU
//   out_tag      tag of the decoded instruction
//   err_sticky   sticky illegal flag
//
// Build option
//   ILLEGAL_TRAP_EN  when defined, illegal words are consumed but never
//                    presented; err_sticky latches until reset and
//                    out_illegal is tied to 0. When undefined, illegal
//                    words are forwarded with out_illegal=1 and err_sticky
//                    is tied to 0.
// -----------------------------------------------------------------------------
module alu_op_decoder #(
  parameter int TAG_W = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      in_instr,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [3:0]       out_alu_op,
  output logic             out_src_imm,
  output logic             out_illegal,
  output logic [TAG_W-1:0] out_tag,
  output logic             err_sticky
);

  typedef enum logic [3:0] {
    ALU_ADD = 4'd0,
    ALU_SUB = 4'd1,
    ALU_SLT = 4'd2,
    ALU_XOR = 4'd3,
    ALU_OR  = 4'd4,
    ALU_AND = 4'd5,
    ALU_SLL = 4'd6,
    ALU_SRL = 4'd7,
    ALU_SRA = 4'd8
  } alu_op_e;

  typedef enum logic [6:0] {
    OPC_OP     = 7'b0110011,
    OPC_OP_IMM = 7'b0010011,
    OPC_LOAD   = 7'b0000011,
    OPC_STORE  = 7'b0100011,
    OPC_JALR   = 7'b1100111,
    OPC_LUI    = 7'b0110111,
    OPC_AUIPC  = 7'b0010111,
    OPC_JAL    = 7'b1101111,
    OPC_BRANCH = 7'b1100011
  } opcode_e;

  localparam logic [6:0] F7_BASE = 7'b0000000;
  localparam logic [6:0] F7_ALT  = 7'b0100000;

  typedef struct packed {
    alu_op_e          op;
    logic             src_imm;
    logic             illegal;
    logic [TAG_W-1:0] tag;
  } entry_t;

  // ---------------------------------------------------------------------------
  // Combinational decode
  // ---------------------------------------------------------------------------
  opcode_e    opc;
  logic [2:0] f3;
  logic [6:0] f7;
  alu_op_e    dec_op;
  logic       dec_imm;
  logic       dec_ill;
  entry_t     dec_entry;

  assign opc = opcode_e'(in_instr[6:0]);
  assign f3  = in_instr[14:12];
  assign f7  = in_instr[31:25];

  // Register fields and immediates play no part in ALU-op selection.
  logic unused_instr_bits;
  assign unused_instr_bits = ^{in_instr[24:15], in_instr[11:7]};

  always_comb begin
    dec_op  = ALU_ADD;
    dec_imm = 1'b0;
    dec_ill = 1'b0;
    unique case (opc)
      OPC_OP: begin
        dec_imm = 1'b0;
        unique case (f3)
          3'b000: begin
            if (f7 == F7_BASE)     dec_op = ALU_ADD;
            else if (f7 == F7_ALT) dec_op = ALU_SUB;
            else                   dec_ill = 1'b1;
          end
          3'b001: begin
            dec_op  = ALU_SLL;
            dec_ill = (f7 != F7_BASE);
          end
          3'b010: begin
            dec_op  = ALU_SLT;
            dec_ill = (f7 != F7_BASE);
          end
          3'b011: dec_ill = 1'b1;
          3'b100: begin
            dec_op  = ALU_XOR;
            dec_ill = (f7 != F7_BASE);
          end
          3'b101: begin
            if (f7 == F7_BASE)     dec_op = ALU_SRL;
            else if (f7 == F7_ALT) dec_op = ALU_SRA;
            else                   dec_ill = 1'b1;
          end
          3'b110: begin
            dec_op  = ALU_OR;
            dec_ill = (f7 != F7_BASE);
          end
          3'b111: begin
            dec_op  = ALU_AND;
            dec_ill = (f7 != F7_BASE);
          end
          default: dec_ill = 1'b1;
        endcase
      end
      OPC_OP_IMM: begin
        dec_imm = 1'b1;
        unique case (f3)
          3'b000: dec_op = ALU_ADD;
          3'b001: begin
            dec_op  = ALU_SLL;
            dec_ill = (f7 != F7_BASE);
          end
          3'b010: dec_op = ALU_SLT;
          3'b011: dec_ill = 1'b1;
          3'b100: dec_op = ALU_XOR;
          3'b101: begin
            if (f7 == F7_BASE)     dec_op = ALU_SRL;
            else if (f7 == F7_ALT) dec_op = ALU_SRA;
            else                   dec_ill = 1'b1;
          end
          3'b110: dec_op = ALU_OR;
          3'b111: dec_op = ALU_AND;
          default: dec_ill = 1'b1;
        endcase
      end
      OPC_LOAD, OPC_STORE, OPC_JALR, OPC_LUI, OPC_AUIPC, OPC_JAL: begin
        dec_op  = ALU_ADD;
        dec_imm = 1'b1;
      end
      OPC_BRANCH: begin
        dec_imm = 1'b0;
        unique case (f3)
          3'b000, 3'b001: dec_op = ALU_SUB;
          3'b100, 3'b101: dec_op = ALU_SLT;
          default:        dec_ill = 1'b1;
        endcase
      end
      default: dec_ill = 1'b1;
    endcase
    // Illegal words always present a neutral ADD with rs2 selected.
    if (dec_ill) begin
      dec_op  = ALU_ADD;
      dec_imm = 1'b0;
    end
  end

  always_comb begin
    dec_entry         = '0;
    dec_entry.op      = dec_op;
    dec_entry.src_imm = dec_imm;
    dec_entry.illegal = dec_ill;
    dec_entry.tag     = in_tag;
  end

  // ---------------------------------------------------------------------------
  // Output register + skid buffer
  // ---------------------------------------------------------------------------
  entry_t main_q;
  entry_t skid_q;
  logic   main_valid;
  logic   skid_full;
  logic   accept;
  logic   push;
  logic   main_free;

  assign in_ready  = !skid_full;
  assign accept    = in_valid && in_ready;
  assign main_free = !main_valid || out_ready;

`ifdef ILLEGAL_TRAP_EN
  // Illegal words complete the handshake but are dropped here.
  assign push = accept && !dec_ill;
`else
  assign push = accept;
`endif

  // The skid only fills while the output register is full and stalled, and
  // in_ready is low while it is full, so a skid entry and a new accept can
  // never compete for the output register on the same edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      main_q     <= '0;
      skid_q     <= '0;
      main_valid <= 1'b0;
      skid_full  <= 1'b0;
    end else if (main_free) begin
      if (skid_full) begin
        main_q     <= skid_q;
        main_valid <= 1'b1;
        skid_full  <= 1'b0;
      end else if (push) begin
        main_q     <= dec_entry;
        main_valid <= 1'b1;
      end else begin
        main_valid <= 1'b0;
      end
    end else if (push) begin
      skid_q    <= dec_entry;
      skid_full <= 1'b1;
    end
  end

  assign out_valid   = main_valid;
  assign out_alu_op  = main_q.op;
  assign out_src_imm = main_q.src_imm;
  assign out_tag     = main_q.tag;

`ifdef ILLEGAL_TRAP_EN
  logic err_q;
  logic unused_main_illegal;

  always_ff @(posedge clk) begin
    if (rst) begin
      err_q <= 1'b0;
    end else if (accept && dec_ill) begin
      err_q <= 1'b1;
    end
  end

  assign err_sticky          = err_q;
  assign out_illegal         = 1'b0;
  assign unused_main_illegal = main_q.illegal;
`else
  assign err_sticky  = 1'b0;
  assign out_illegal = main_q.illegal;
`endif

endmodule

// File: tb/tb_alu_op_decoder.sv
module tb_alu_op_decoder;

  localparam int TAG_W = 5;

  logic             clk;
  logic             rst;
  logic             in_valid;
  logic             in_ready;
  logic [31:0]      in_instr;
  logic [TAG_W-1:0] in_tag;
  logic             out_valid;
  logic             out_ready;
  logic [3:0]       out_alu_op;
  logic             out_src_imm;
  logic             out_illegal;
  logic [TAG_W-1:0] out_tag;
  logic             err_sticky;

  alu_op_decoder #(.TAG_W(TAG_W)) dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_instr   (in_instr),
    .in_tag     (in_tag),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_alu_op (out_alu_op),
    .out_src_imm(out_src_imm),
    .out_illegal(out_illegal),
    .out_tag    (out_tag),
    .err_sticky (err_sticky)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

`ifdef ILLEGAL_TRAP_EN
  localparam bit TRAP = 1'b1;
`else
  localparam bit TRAP = 1'b0;
`endif

  typedef struct {
    int unsigned op;
    bit          imm;
    bit          ill;
    int unsigned tag;
  } exp_t;

  exp_t q[$];
  bit   m_err;
  int   n_cmp;
  int   n_bad;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, got, exp, $time);
    end
  endtask

  // Reference decode straight from the ISA tables:
  // ADD=0 SUB=1 SLT=2 XOR=3 OR=4 AND=5 SLL=6 SRL=7 SRA=8.
  function automatic exp_t ref_decode(input logic [31:0] w, input logic [TAG_W-1:0] t);
    int unsigned base_op [8] = '{0, 6, 2, 0, 3, 7, 4, 5};
    int unsigned opc = int'(w[6:0]);
    int unsigned f3  = int'(w[14:12]);
    int unsigned f7  = int'(w[31:25]);
    exp_t e;
    e.tag = int'(t);
    e.op  = 0;
    e.imm = 0;
    e.ill = 0;
    if (opc == 'h33) begin
      if (f3 == 3)                      e.ill = 1;
      else if (f7 == 0)                 e.op = base_op[f3];
      else if (f7 == 'h20 && f3 == 0)   e.op = 1;
      else if (f7 == 'h20 && f3 == 5)   e.op = 8;
      else                              e.ill = 1;
    end else if (opc == 'h13) begin
      e.imm = 1;
      if (f3 == 3)                      e.ill = 1;
      else if (f3 == 1 || f3 == 5) begin
        if (f7 == 0)                    e.op = base_op[f3];
        else if (f7 == 'h20 && f3 == 5) e.op = 8;
        else                            e.ill = 1;
      end else                          e.op = base_op[f3];
    end else if (opc == 'h03 || opc == 'h23 || opc == 'h67 ||
                 opc == 'h37 || opc == 'h17 || opc == 'h6F) begin
      e.imm = 1;
    end else if (opc == 'h63) begin
      if (f3 / 2 == 0)      e.op = 1;
      else if (f3 / 2 == 2) e.op = 2;
      else                  e.ill = 1;
    end else begin
      e.ill = 1;
    end
    if (e.ill) begin
      e.op  = 0;
      e.imm = 0;
    end
    if (TRAP) e.ill = 0;
    return e;
  endfunction

  function automatic logic [31:0] rand_instr();
    logic [6:0] opcs [10] = '{7'h33, 7'h13, 7'h03, 7'h23, 7'h67,
                              7'h37, 7'h17, 7'h6F, 7'h63, 7'h33};
    logic [31:0] w = $urandom;
    int unsigned k = $urandom_range(0, 11);
    if (k < 10) w[6:0] = opcs[k];
    else if (k == 10) w[6:0] = 7'h13;
    case ($urandom_range(0, 3))
      0, 1: w[31:25] = 7'h00;
      2:    w[31:25] = 7'h20;
      default: ;
    endcase
    return w;
  endfunction

  // One clock: drive inputs, check registered outputs against the queue
  // model, advance the model by the handshakes that happen on this edge.
  task automatic step(input logic v, input logic [31:0] w, input logic [TAG_W-1:0] t,
                      input logic ordy);
    exp_t e;
    bit   acc;
    bit   drn;
    in_valid  = v;
    in_instr  = w;
    in_tag    = t;
    out_ready = ordy;
    check("out_valid", 32'(out_valid), 32'(q.size() > 0));
    check("in_ready", 32'(in_ready), 32'(q.size() < 2));
    check("err_sticky", 32'(err_sticky), 32'(m_err));
    if (q.size() > 0) begin
      check("alu_op", 32'(out_alu_op), q[0].op);
      check("src_imm", 32'(out_src_imm), 32'(q[0].imm));
      check("illegal", 32'(out_illegal), 32'(q[0].ill));
      check("tag", 32'(out_tag), q[0].tag);
    end
    acc = v && (q.size() < 2);
    drn = (q.size() > 0) && ordy;
    if (drn) void'(q.pop_front());
    if (acc) begin
      e = ref_decode(w, t);
      if (TRAP && ref_decode_is_illegal(w)) m_err = 1;
      else q.push_back(e);
    end
    @(posedge clk);
    #1;
  endtask

  function automatic bit ref_decode_is_illegal(input logic [31:0] w);
    exp_t e;
    int unsigned opc = int'(w[6:0]);
    e = ref_decode(w, '0);
    // With the trap build the ill field is masked, so re-derive legality:
    // a legal word that maps to ADD/rs2 is only R-type add or a branch-free case.
    if (!TRAP) return e.ill;
    if (e.op != 0 || e.imm) return 0;
    if (opc == 'h33 && w[14:12] == 3'b000 && w[31:25] == 7'h00) return 0;
    return 1;
  endfunction

  task automatic do_reset(input int unsigned cycles);
    rst       = 1'b1;
    in_valid  = 1'b1;
    in_instr  = 32'h003100B3;
    in_tag    = 5'd7;
    out_ready = 1'b0;
    for (int unsigned i = 0; i < cycles; i++) begin
      @(posedge clk);
      #1;
    end
    rst = 1'b0;
    in_valid = 1'b0;
    q.delete();
    m_err = 0;
    check("rst out_valid", 32'(out_valid), 32'd0);
    check("rst in_ready", 32'(in_ready), 32'd1);
    check("rst alu_op", 32'(out_alu_op), 32'd0);
    check("rst src_imm", 32'(out_src_imm), 32'd0);
    check("rst illegal", 32'(out_illegal), 32'd0);
    check("rst tag", 32'(out_tag), 32'd0);
    check("rst err_sticky", 32'(err_sticky), 32'd0);
  endtask

  initial begin
    n_cmp = 0;
    n_bad = 0;
    m_err = 0;
    rst = 1'b1;
    in_valid = 1'b0;
    in_instr = '0;
    in_tag = '0;
    out_ready = 1'b0;
    #1;

    // 1: reset, then add x1,x2,x3
    do_reset(2);
    step(1, 32'h003100B3, 5'd1, 1);
    check("add alu_op", 32'(out_alu_op), 32'd0);
    check("add src_imm", 32'(out_src_imm), 32'd0);
    step(0, 32'h0, 5'd0, 1);

    // 2: sub then srai back to back
    step(1, 32'h403100B3, 5'd2, 1);
    check("sub alu_op", 32'(out_alu_op), 32'd1);
    step(1, 32'h40315093, 5'd3, 1);
    check("srai alu_op", 32'(out_alu_op), 32'd8);
    check("srai src_imm", 32'(out_src_imm), 32'd1);
    step(0, 32'h0, 5'd0, 1);

    // 3: stall with three pending, then drain in order
    step(1, 32'h003100B3, 5'd4, 0);
    step(1, 32'h403100B3, 5'd5, 0);
    step(1, 32'h40315093, 5'd6, 0);
    step(1, 32'h40315093, 5'd6, 0);
    step(1, 32'h40315093, 5'd6, 1);
    step(1, 32'h40315093, 5'd6, 1);
    for (int i = 0; i < 3; i++) step(0, 32'h0, 5'd0, 1);

    // 4: sltu
    step(1, 32'h003130B3, 5'd8, 1);
    for (int i = 0; i < 3; i++) step(0, 32'h0, 5'd0, 1);

    // 5: blt, bltu
    step(1, 32'h0020C463, 5'd9, 1);
    check("blt alu_op", 32'(out_alu_op), 32'd2);
    step(1, 32'h0020E463, 5'd10, 1);
    step(0, 32'h0, 5'd0, 1);

    // 6: reset with output and skid both full
    step(1, 32'h003100B3, 5'd11, 0);
    step(1, 32'h403100B3, 5'd12, 0);
    step(0, 32'h0, 5'd0, 0);
    do_reset(1);
    for (int i = 0; i < 3; i++) step(0, 32'h0, 5'd0, 1);

    // Randomized traffic with occasional resets
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 299) == 0) do_reset(1);
      step(logic'($urandom_range(0, 9) < 7), rand_instr(), TAG_W'($urandom),
           logic'($urandom_range(0, 9) < 6));
    end
    for (int i = 0; i < 4; i++) step(0, 32'h0, 5'd0, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/alu_op_decoder.md
Name: alu_op_decoder

Overview:
- Producer end of the 4-bit ALU opcode interface.
- Takes RV32I instruction words from fetch/issue over a valid/ready handshake and decodes opcode, funct3 and funct7/imm[11:5] into the ALU operation encoding and operand-B select.
- Delivers the result through a registered, back-pressurable output stage with a skid buffer, so the pipeline stage ahead of the ALU is timing-isolated.

Parameters:
- TAG_W, 5, width of the opaque tag (e.g. rd index) carried alongside each instruction.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  instruction word valid.
- in_ready  out  1  decoder can accept; transfer when in_valid && in_ready.
- in_instr  in  32  RV32I instruction word.
- in_tag  in  TAG_W  passthrough tag.
- out_valid  out  1  decoded result valid.
- out_ready  in  1  consumer accepts; transfer when out_valid && out_ready.
- out_alu_op  out  4  ALU opcode.
- out_src_imm  out  1  1 = operand B is the immediate, 0 = rs2.
- out_illegal  out  1  instruction not executable by the ALU.
- out_tag  out  TAG_W  tag of the decoded instruction.
- err_sticky  out  1  sticky illegal flag (used only under the optional feature).

Behaviour:
- Reset (synchronous, rst=1 at edge):
  - out_valid=0, out_alu_op=0, out_src_imm=0, out_illegal=0, out_tag=0, err_sticky=0, skid empty.
  - in_ready=1 from the first cycle after reset.
  - Reset mid-transfer discards both main and skid entries; nothing is replayed.
- ALU opcode encoding:
  - 0000 ADD, 0001 SUB, 0010 SLT, 0011 XOR, 0100 OR, 0101 AND, 0110 SLL, 0111 SRL, 1000 SRA.
  - All other codes are never produced.
- Decode for R-type, opcode 0110011, src_imm=0:
  - funct3 000: f7=0000000 ADD; f7=0100000 SUB.
  - 001 SLL; 010 SLT; 100 XOR; 101 SRL (f7=0000000) or SRA (f7=0100000); 110 OR; 111 AND.
  - funct3 011 (SLTU) is illegal.
  - Any other f7 is illegal, except the two listed values at 000 and 101.
- Decode for I-ALU, opcode 0010011, src_imm=1:
  - 000 ADD; 010 SLT; 100 XOR; 110 OR; 111 AND.
  - 001 SLL requires imm[11:5]=0000000.
  - 101: SRL with imm[11:5]=0000000; SRA with imm[11:5]=0100000.
  - 011 is illegal; any other imm[11:5] on a shift is illegal.
- Load 0000011, store 0100011, JALR 1100111: ADD, src_imm=1.
- LUI 0110111, AUIPC 0010111, JAL 1101111: ADD, src_imm=1.
- Branch 1100011, src_imm=0:
  - funct3 000/001 SUB; 100/101 SLT.
  - 010, 011, 110, 111 are illegal.
- Any other opcode is illegal.
- Every illegal decode forces alu_op=0000 and src_imm=0.
- Latency: accepted at edge N; visible on out_* after edge N (1 cycle).
- Output register:
  - Loads when empty, or when full and out_ready=1 (pipelined throughput 1/cycle).
  - out_* stay stable while out_valid=1 && out_ready=0.
- Skid buffer:
  - in_ready is a registered signal = !skid_full.
  - If data is accepted while the output is full and not drained, the decoded entry goes to the skid.
  - While the skid is full, in_ready=0.
  - When the output drains, the skid moves to the output the same edge, and the skid empties.
  - Order is strictly preserved.
- Simultaneous accept and drain with the skid empty: output replaced by the new entry, out_valid stays 1.
- in_instr and in_tag are ignored when in_valid=0.

Optional Feature:
- Macro: ILLEGAL_TRAP_EN.
- Defined:
  - Illegal instructions are consumed (in_ready handshake honoured) but never presented; out_valid stays 0 for them.
  - err_sticky is set on the edge the illegal word is accepted and holds until rst.
  - out_illegal is constant 0.
- Undefined:
  - Illegal instructions are forwarded normally with out_illegal=1, alu_op=0000.
  - err_sticky is constant 0.

Test Plan:
- 1. rst=1 two cycles, then release -> out_valid=0, in_ready=1, all outputs 0; in_instr=0x003100B3 (add x1,x2,x3), tag=1 -> next cycle out_valid=1, alu_op=0000, src_imm=0, illegal=0, tag=1.
- 2. Back-to-back 0x403100B3 (sub), 0x40315093 (srai x1,x2,3), out_ready=1 -> alu_op 0001 (src_imm=0) then 1000 (src_imm=1) on consecutive cycles.
- 3. out_ready=0, send 3 instructions -> first held stable on outputs, second in skid, in_ready=0 after second; raise out_ready -> all three emerge in order, no loss or duplication.
- 4. 0x003130B3 (sltu) -> macro undefined: out_illegal=1, alu_op=0000; macro defined: no out_valid, err_sticky=1 until rst.
- 5. Branch 0x0020C463 (blt) -> alu_op 0010, src_imm=0; 0x0020E463 (bltu) -> illegal.
- 6. Assert rst with output and skid both full -> next cycle out_valid=0, in_ready=1, nothing from the old entries reappears.
